// File: rtl/gate_tester_pkg.sv
// Shared gate-tester definitions: command codes, transfer-engine states, standard windows.
package gate_tester_pkg;

    localparam logic [7:0] CMD_READ  = 8'h00;
    localparam logic [7:0] CMD_WRITE = 8'h01;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RX_WAIT = 3'd1,
        TX_RD   = 3'd2,
        TX_LOAD = 3'd3,
        TX_HOLD = 3'd4
    } state_e;

    localparam logic [15:0] DUT_WIN_START = 16'h0000;
    localparam logic [15:0] DUT_WIN_END   = 16'h0007;
    localparam logic [15:0] IN_WIN_START  = 16'h0008;
    localparam logic [15:0] IN_WIN_END    = 16'h000F;

    // Cycles after tx_start to wait for tx_busy before assuming a fast transmitter.
    localparam int unsigned TX_FALLBACK_CYCLES = 2;

    // A window is legal when it does not run backwards.
    function automatic logic window_ok(input logic [15:0] first, input logic [15:0] last);
        return first <= last;
    endfunction

endpackage

// File: rtl/byte_ram.sv
// Single-port synchronous byte RAM with one-cycle read latency.
module byte_ram #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        wdata,
    output logic [7:0]        rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [7:0] mem [DEPTH];

    // Write on we; register the addressed byte on re (read data holds otherwise).
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/uart_mem_processor.sv
// Command-driven UART <-> byte-memory transfer engine for the gate tester.
module uart_mem_processor
    import gate_tester_pkg::*;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter logic [7:0]  CMD_READ  = gate_tester_pkg::CMD_READ,
    parameter logic [7:0]  CMD_WRITE = gate_tester_pkg::CMD_WRITE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    input  logic [7:0]  command,
    input  logic [15:0] start_address,
    input  logic [15:0] end_address,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        tx_busy,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    output logic        rx_done,
    output logic        tx_done,
    output logic        busy,
    output logic        cmd_err
);

    localparam logic [2:0] S_IDLE    = IDLE;
    localparam logic [2:0] S_RX_WAIT = RX_WAIT;
    localparam logic [2:0] S_TX_RD   = TX_RD;
    localparam logic [2:0] S_TX_LOAD = TX_LOAD;
    localparam logic [2:0] S_TX_HOLD = TX_HOLD;

    logic [2:0]  state,     state_nxt;
    logic [15:0] addr,      addr_nxt;
    logic [15:0] end_addr,  end_addr_nxt;
    logic [7:0]  tx_data_nxt;
    logic        tx_start_nxt;
    logic        rx_done_nxt;
    logic        tx_done_nxt;
    logic        busy_nxt;
    logic        cmd_err_nxt;
    logic [1:0]  hold_cnt,  hold_cnt_nxt;
    logic        seen_busy, seen_busy_nxt;
    logic        byte_sent;
    logic        cmd_ok;

    logic        ram_we;
    logic        ram_re;
    logic [7:0]  ram_rdata;

    byte_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (addr[ADDR_W-1:0]),
        .wdata (rx_data),
        .rdata (ram_rdata)
    );

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            addr      <= 16'd0;
            end_addr  <= 16'd0;
            tx_data   <= 8'd0;
            tx_start  <= 1'b0;
            rx_done   <= 1'b0;
            tx_done   <= 1'b0;
            busy      <= 1'b0;
            cmd_err   <= 1'b0;
            hold_cnt  <= 2'd0;
            seen_busy <= 1'b0;
        end else begin
            state     <= state_nxt;
            addr      <= addr_nxt;
            end_addr  <= end_addr_nxt;
            tx_data   <= tx_data_nxt;
            tx_start  <= tx_start_nxt;
            rx_done   <= rx_done_nxt;
            tx_done   <= tx_done_nxt;
            busy      <= busy_nxt;
            cmd_err   <= cmd_err_nxt;
            hold_cnt  <= hold_cnt_nxt;
            seen_busy <= seen_busy_nxt;
        end
    end

    // Next-state, RAM control and next-output logic.
    always_comb begin
        state_nxt     = state;
        addr_nxt      = addr;
        end_addr_nxt  = end_addr;
        tx_data_nxt   = tx_data;
        tx_start_nxt  = 1'b0;
        rx_done_nxt   = rx_done;
        tx_done_nxt   = tx_done;
        cmd_err_nxt   = cmd_err;
        hold_cnt_nxt  = hold_cnt;
        seen_busy_nxt = seen_busy;
        byte_sent     = 1'b0;
        ram_we        = 1'b0;
        ram_re        = 1'b0;
        cmd_ok        = window_ok(start_address, end_address) &&
                        ((command == CMD_READ) || (command == CMD_WRITE));

        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (!cmd_ok) begin
                        cmd_err_nxt = 1'b1;
                    end else begin
                        rx_done_nxt  = 1'b0;
                        tx_done_nxt  = 1'b0;
                        cmd_err_nxt  = 1'b0;
                        addr_nxt     = start_address;
                        end_addr_nxt = end_address;
                        state_nxt    = (command == CMD_WRITE) ? S_RX_WAIT : S_TX_RD;
                    end
                end
            end

            S_RX_WAIT: begin
                if (rx_valid) begin
                    ram_we = 1'b1;
                    if (addr == end_addr) begin
                        rx_done_nxt = 1'b1;
                        state_nxt   = S_IDLE;
                    end else begin
                        addr_nxt = addr + 16'd1;
                    end
                end
            end

            S_TX_RD: begin
                ram_re    = 1'b1;
                state_nxt = S_TX_LOAD;
            end

            S_TX_LOAD: begin
                if (!tx_busy) begin
                    tx_data_nxt   = ram_rdata;
                    tx_start_nxt  = 1'b1;
                    hold_cnt_nxt  = 2'd0;
                    seen_busy_nxt = 1'b0;
                    state_nxt     = S_TX_HOLD;
                end
            end

            S_TX_HOLD: begin
                // Wait for a busy pulse to finish, or give up waiting for it to start.
                if (tx_busy) begin
                    seen_busy_nxt = 1'b1;
                end else if (seen_busy || (hold_cnt == 2'(TX_FALLBACK_CYCLES))) begin
                    byte_sent = 1'b1;
                end else begin
                    hold_cnt_nxt = hold_cnt + 2'd1;
                end

                if (byte_sent) begin
                    if (addr == end_addr) begin
                        tx_done_nxt = 1'b1;
                        state_nxt   = S_IDLE;
                    end else begin
                        addr_nxt  = addr + 16'd1;
                        state_nxt = S_TX_RD;
                    end
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        busy_nxt = (state_nxt != S_IDLE);
    end

endmodule

// File: tb/tb_uart_mem_processor.sv
// Scoreboard bench for uart_mem_processor with a simple UART transmitter model.
module tb_uart_mem_processor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [7:0]  command = 8'h00;
    logic [15:0] start_address = 16'h0000;
    logic [15:0] end_address = 16'h0000;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        tx_busy = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        rx_done;
    logic        tx_done;
    logic        busy;
    logic        cmd_err;

    int          vectors = 0;
    int          miscompares = 0;
    int          tx_cnt = 0;
    logic        tx_mode = 1'b1;
    logic        busy_q = 1'b0;
    logic [7:0]  model_mem [256];
    logic [7:0]  exp_q [$];

    uart_mem_processor dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid     (cmd_valid),
        .command       (command),
        .start_address (start_address),
        .end_address   (end_address),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .tx_busy       (tx_busy),
        .tx_data       (tx_data),
        .tx_start      (tx_start),
        .rx_done       (rx_done),
        .tx_done       (tx_done),
        .busy          (busy),
        .cmd_err       (cmd_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Transmitter model: busy for 10 cycles after each tx_start when tx_mode is set.
    always begin
        @(posedge clk);
        #1;
        if (tx_start && tx_mode) begin
            tx_busy = 1'b1;
            repeat (10) @(posedge clk);
            #1;
            tx_busy = 1'b0;
        end
    end

    // tx_busy as seen by the DUT at the coming rising edge.
    always @(negedge clk) busy_q = tx_busy;

    // Scoreboard: every tx_start pops one expected byte.
    always begin
        @(posedge clk);
        #1;
        if (tx_start) begin
            tx_cnt++;
            chk("tx_start_while_busy", 32'(busy_q), 32'd0);
            chk("tx_q_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                chk("tx_data", 32'(tx_data), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic issue(input logic [7:0] c, input logic [15:0] s, input logic [15:0] e);
        command       = c;
        start_address = s;
        end_address   = e;
        cmd_valid     = 1'b1;
        tick();
        cmd_valid     = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles);
        int n = 0;
        while (busy && n < max_cycles) begin
            tick();
            n++;
        end
        chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    // Write a window byte by byte with random gaps, checking rx_done timing.
    task automatic write_window(input logic [15:0] s, input logic [15:0] e, input logic [7:0] base);
        int n = int'(e) - int'(s) + 1;
        issue(8'h01, s, e);
        chk("wr_busy", 32'(busy), 32'd1);
        chk("wr_cmd_err", 32'(cmd_err), 32'd0);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 5)) tick();
            rx_data  = base + 8'(i);
            rx_valid = 1'b1;
            model_mem[8'(int'(s) + i)] = base + 8'(i);
            tick();
            rx_valid = 1'b0;
            chk("rx_done", 32'(rx_done), 32'(i == n - 1));
        end
        chk("wr_busy_end", 32'(busy), 32'd0);
    endtask

    // Read a window back; expected bytes come from the bench memory model.
    task automatic read_window(input logic [15:0] s, input logic [15:0] e);
        int n = int'(e) - int'(s) + 1;
        int t0 = tx_cnt;
        for (int i = 0; i < n; i++) exp_q.push_back(model_mem[8'(int'(s) + i)]);
        issue(8'h00, s, e);
        chk("rd_busy", 32'(busy), 32'd1);
        wait_idle(2000);
        tick();
        chk("rd_count", 32'(tx_cnt - t0), 32'(n));
        chk("rd_tx_done", 32'(tx_done), 32'd1);
        chk("rd_q_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int t0;
        int n;

        // Reset values.
        repeat (3) tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_tx_start", 32'(tx_start), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_rx_done", 32'(rx_done), 32'd0);
        chk("rst_tx_done", 32'(tx_done), 32'd0);
        chk("rst_cmd_err", 32'(cmd_err), 32'd0);
        rst_n = 1'b1;
        tick();

        // Input window write, then a stray byte that must be dropped.
        write_window(16'h0008, 16'h000F, 8'hA0);
        rx_data  = 8'hEE;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        tick();
        chk("stray_rx_done", 32'(rx_done), 32'd1);
        chk("stray_busy", 32'(busy), 32'd0);

        // Readback with a slow transmitter.
        read_window(16'h0008, 16'h000F);
        chk("rd_rx_done_cleared", 32'(rx_done), 32'd0);

        // Single-byte window.
        write_window(16'h0003, 16'h0003, 8'h5C);
        read_window(16'h0003, 16'h0003);

        // Rejected commands leave flags and state alone apart from cmd_err.
        issue(8'h07, 16'h0000, 16'h0001);
        tick();
        chk("badcmd_err", 32'(cmd_err), 32'd1);
        chk("badcmd_busy", 32'(busy), 32'd0);
        chk("badcmd_tx_done", 32'(tx_done), 32'd1);
        issue(8'h00, 16'h0010, 16'h000F);
        tick();
        chk("badwin_err", 32'(cmd_err), 32'd1);
        chk("badwin_busy", 32'(busy), 32'd0);
        issue(8'h01, 16'h0020, 16'h0021);
        chk("clr_cmd_err", 32'(cmd_err), 32'd0);
        chk("clr_tx_done", 32'(tx_done), 32'd0);
        chk("clr_busy", 32'(busy), 32'd1);
        rx_data  = 8'h11;
        rx_valid = 1'b1;
        model_mem[8'h20] = 8'h11;
        tick();
        rx_data  = 8'h22;
        model_mem[8'h21] = 8'h22;
        tick();
        rx_valid = 1'b0;
        chk("b2b_rx_done", 32'(rx_done), 32'd1);

        // A command during TX_HOLD is ignored.
        for (int i = 0; i < 8; i++) exp_q.push_back(model_mem[8'(8 + i)]);
        t0 = tx_cnt;
        issue(8'h00, 16'h0008, 16'h000F);
        n = 0;
        while (tx_cnt == t0 && n < 100) begin
            tick();
            n++;
        end
        chk("first_start_timeout", 32'(tx_cnt > t0), 32'd1);
        tick();
        issue(8'h01, 16'h0040, 16'h0041);
        chk("ignored_busy", 32'(busy), 32'd1);
        chk("ignored_cmd_err", 32'(cmd_err), 32'd0);
        wait_idle(2000);
        tick();
        chk("ignored_count", 32'(tx_cnt - t0), 32'd8);
        chk("ignored_tx_done", 32'(tx_done), 32'd1);
        chk("ignored_rx_done", 32'(rx_done), 32'd0);
        chk("ignored_q", 32'(exp_q.size()), 32'd0);

        // Fast transmitter that never raises tx_busy.
        tx_mode = 1'b0;
        read_window(16'h0008, 16'h000B);
        read_window(16'h0020, 16'h0021);
        tx_mode = 1'b1;

        // Reset in the middle of a write window.
        issue(8'h01, 16'h0030, 16'h0037);
        rx_data  = 8'h71;
        rx_valid = 1'b1;
        model_mem[8'h30] = 8'h71;
        tick();
        rx_data  = 8'h72;
        model_mem[8'h31] = 8'h72;
        tick();
        rx_valid = 1'b0;
        chk("mid_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_rx_done", 32'(rx_done), 32'd0);
        chk("mid_rst_tx_start", 32'(tx_start), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_rx_done", 32'(rx_done), 32'd0);
        read_window(16'h0030, 16'h0031);

        repeat (5) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
